// File: rtl/countdown_timer_if.sv
// Control/status bundle for countdown_timer: the game logic drives the master side
// and the timer sits on the slave side.
interface countdown_timer_if #(parameter int W = 8);
  logic         start;
  logic [W-1:0] load_val;
  logic         auto_reload;
  logic         pause;
  logic         abort;
  logic [W-1:0] count;
  logic         busy;
  logic         done;
  logic         expired;

  modport master (
    output start, load_val, auto_reload, pause, abort,
    input  count, busy, done, expired
  );
  modport slave (
    input  start, load_val, auto_reload, pause, abort,
    output count, busy, done, expired
  );
endinterface

// File: rtl/countdown_timer.sv
// Loadable, prescaled down-counter with pause, abort and auto-reload.
// Emits a one-cycle expired pulse on each expiry and holds done in DONE.
module countdown_timer #(
  parameter int W        = 8,
  parameter int PRESCALE = 4
) (
  input  logic            clk,
  input  logic            rst,
  countdown_timer_if.slave bus
);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_t;

  state_t        state, state_n;
  logic [W-1:0]  count, count_n;
  logic [W-1:0]  reload_val, reload_val_n;
  logic          reload_mode, reload_mode_n;
  logic [PW-1:0] pre, pre_n;
  logic          expired, expired_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      count       <= '0;
      reload_val  <= '0;
      reload_mode <= 1'b0;
      pre         <= '0;
      expired     <= 1'b0;
    end else begin
      state       <= state_n;
      count       <= count_n;
      reload_val  <= reload_val_n;
      reload_mode <= reload_mode_n;
      pre         <= pre_n;
      expired     <= expired_n;
    end
  end

  always_comb begin
    state_n       = state;
    count_n       = count;
    reload_val_n  = reload_val;
    reload_mode_n = reload_mode;
    pre_n         = pre;
    expired_n     = 1'b0;
    if (bus.abort) begin
      state_n = IDLE;
      count_n = '0;
      pre_n   = '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            if (bus.load_val != '0) begin
              state_n       = RUN;
              count_n       = bus.load_val;
              reload_val_n  = bus.load_val;
              reload_mode_n = bus.auto_reload;
              pre_n         = '0;
            end else begin
              state_n   = DONE;
              count_n   = '0;
              expired_n = 1'b1;
            end
          end
        end
        RUN, HOLD: begin
          // Leaving HOLD counts on the same edge, so each held cycle costs exactly one.
          if (bus.pause) begin
            state_n = HOLD;
          end else begin
            state_n = RUN;
            if (pre != PMAX) begin
              pre_n = pre + 1'b1;
            end else begin
              pre_n = '0;
              if (count > W'(1)) begin
                count_n = count - 1'b1;
              end else if (reload_mode) begin
                count_n   = reload_val;
                expired_n = 1'b1;
              end else begin
                count_n   = '0;
                expired_n = 1'b1;
                state_n   = DONE;
              end
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign bus.count   = count;
  assign bus.expired = expired;
  assign bus.busy    = (state == RUN) || (state == HOLD);
  assign bus.done    = (state == DONE);
endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: directed scenarios on a PRESCALE=4 and a
// PRESCALE=1 instance, then random stimulus against a behavioural timer model.
module tb_countdown_timer;
  localparam int P = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  countdown_timer_if #(.W(8)) ia ();
  countdown_timer_if #(.W(8)) ib ();

  countdown_timer #(.W(8), .PRESCALE(P)) u_a (.clk(clk), .rst(rst), .bus(ia.slave));
  countdown_timer #(.W(8), .PRESCALE(1)) u_b (.clk(clk), .rst(rst), .bus(ib.slave));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(bit st, int lv, bit ar, bit pz, bit ab);
    ia.start = st; ia.load_val = 8'(lv); ia.auto_reload = ar; ia.pause = pz; ia.abort = ab;
  endtask

  task automatic test_reset();
    drive_a(0, 0, 0, 0, 0);
    ib.start = 0; ib.load_val = '0; ib.auto_reload = 0; ib.pause = 0; ib.abort = 0;
    rst = 1'b1;
    step();
    step();
    checks++;
    if ({ia.count, ia.busy, ia.done, ia.expired} !== 11'd0) begin
      errors++; $display("FAIL reset_a got %h/%b%b%b want 0", ia.count, ia.busy, ia.done, ia.expired);
    end
    checks++;
    if ({ib.count, ib.busy, ib.done, ib.expired} !== 11'd0) begin
      errors++; $display("FAIL reset_b got %h/%b%b%b want 0", ib.count, ib.busy, ib.done, ib.expired);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    logic [7:0] ec;
    drive_a(1, 3, 0, 0, 0);
    for (int e = 0; e <= 13; e++) begin
      step();
      if (e == 0) drive_a(0, 0, 0, 0, 0);
      ec = (e < 4) ? 8'd3 : (e < 8) ? 8'd2 : (e < 12) ? 8'd1 : 8'd0;
      checks++;
      if (ia.count !== ec || ia.expired !== (e == 12) || ia.done !== (e >= 12) || ia.busy !== (e < 12)) begin
        errors++;
        $display("FAIL basic e=%0d got c=%0d x=%b d=%b b=%b want c=%0d x=%b d=%b b=%b",
                 e, ia.count, ia.expired, ia.done, ia.busy, ec, e == 12, e >= 12, e < 12);
      end
    end
  endtask

  task automatic test_pause();
    logic [7:0] ec;
    drive_a(1, 3, 0, 0, 0);
    for (int e = 0; e <= 16; e++) begin
      step();
      drive_a(0, 0, 0, (e >= 4 && e <= 6), 0);
      ec = (e < 4) ? 8'd3 : (e < 11) ? 8'd2 : (e < 15) ? 8'd1 : 8'd0;
      checks++;
      if (ia.count !== ec || ia.expired !== (e == 15) || ia.busy !== (e < 15)) begin
        errors++;
        $display("FAIL pause e=%0d got c=%0d x=%b b=%b want c=%0d x=%b b=%b",
                 e, ia.count, ia.expired, ia.busy, ec, e == 15, e < 15);
      end
    end
  endtask

  // Also covers abort landing on the same edge as a count=1 reload tick (edge 32).
  task automatic test_reload();
    logic [7:0] ec;
    drive_a(1, 2, 1, 0, 0);
    for (int e = 0; e <= 31; e++) begin
      step();
      drive_a(0, 5, 0, 0, (e == 31));
      ec = ((e / 4) % 2 == 0) ? 8'd2 : 8'd1;
      checks++;
      if (ia.count !== ec || ia.expired !== (e > 0 && e % 8 == 0) || ia.done !== 1'b0 || ia.busy !== 1'b1) begin
        errors++;
        $display("FAIL reload e=%0d got c=%0d x=%b d=%b b=%b want c=%0d x=%b d=0 b=1",
                 e, ia.count, ia.expired, ia.done, ia.busy, ec, e > 0 && e % 8 == 0);
      end
    end
    step();
    drive_a(0, 0, 0, 0, 0);
    checks++;
    if ({ia.count, ia.busy, ia.done, ia.expired} !== 11'd0) begin
      errors++; $display("FAIL reload_abort got %h/%b%b%b want 0", ia.count, ia.busy, ia.done, ia.expired);
    end
  endtask

  task automatic test_zero_load();
    drive_a(1, 0, 0, 0, 0);
    step();
    drive_a(0, 0, 0, 0, 0);
    checks++;
    if (ia.count !== 8'd0 || ia.expired !== 1'b1 || ia.done !== 1'b1 || ia.busy !== 1'b0) begin
      errors++; $display("FAIL zero_load got c=%0d x=%b d=%b b=%b want 0 1 1 0", ia.count, ia.expired, ia.done, ia.busy);
    end
    step();
    checks++;
    if (ia.expired !== 1'b0 || ia.done !== 1'b1) begin
      errors++; $display("FAIL zero_load_after got x=%b d=%b want 0 1", ia.expired, ia.done);
    end
  endtask

  task automatic test_start_ignored();
    drive_a(1, 5, 0, 0, 0);
    step();
    drive_a(0, 0, 0, 0, 0);
    step();
    drive_a(1, 9, 1, 0, 0);
    step();
    drive_a(0, 0, 0, 0, 0);
    checks++;
    if (ia.count !== 8'd5) begin
      errors++; $display("FAIL start_ignored got %0d want 5", ia.count);
    end
    step();
    step();
    checks++;
    if (ia.count !== 8'd4) begin
      errors++; $display("FAIL start_ignored_dec got %0d want 4", ia.count);
    end
    drive_a(0, 0, 0, 0, 1);
    step();
    drive_a(0, 0, 0, 0, 0);
  endtask

  task automatic test_abort_start_done();
    drive_a(1, 0, 0, 0, 0);
    step();
    drive_a(1, 7, 0, 0, 1);
    step();
    drive_a(0, 0, 0, 0, 0);
    checks++;
    if ({ia.count, ia.busy, ia.done, ia.expired} !== 11'd0) begin
      errors++; $display("FAIL abort_start got %h/%b%b%b want 0", ia.count, ia.busy, ia.done, ia.expired);
    end
  endtask

  task automatic test_async_reset();
    drive_a(1, 5, 0, 0, 0);
    step();
    drive_a(0, 0, 0, 0, 0);
    step();
    #2 rst = 1'b1;
    #1;
    checks++;
    if (ia.count !== 8'd0 || ia.busy !== 1'b0 || ia.expired !== 1'b0) begin
      errors++; $display("FAIL async_rst got c=%0d b=%b x=%b want 0", ia.count, ia.busy, ia.expired);
    end
    step();
    rst = 1'b0;
    step();
    ib.start = 1'b1; ib.load_val = 8'd1;
    step();
    ib.start = 1'b0; ib.load_val = 8'd0;
    checks++;
    if (ib.count !== 8'd1 || ib.busy !== 1'b1) begin
      errors++; $display("FAIL p1_start got c=%0d b=%b want 1 1", ib.count, ib.busy);
    end
    step();
    checks++;
    if (ib.count !== 8'd0 || ib.expired !== 1'b1 || ib.done !== 1'b1) begin
      errors++; $display("FAIL p1_expire got c=%0d x=%b d=%b want 0 1 1", ib.count, ib.expired, ib.done);
    end
  endtask

  // Reference timer: remaining count plus cycles left until the next decrement.
  task automatic test_random();
    int  m_count = 0, m_rv = 0, m_left = 0;
    bit  m_run = 0, m_done = 0, m_mode = 0, m_exp = 0;
    bit  st, ar, pz, ab;
    int  lv;
    drive_a(0, 0, 0, 0, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int c = 0; c < 400; c++) begin
      st = ($urandom_range(0, 5) == 0);
      lv = $urandom_range(0, 5);
      ar = 1'($urandom_range(0, 1));
      pz = ($urandom_range(0, 4) == 0);
      ab = ($urandom_range(0, 40) == 0);
      drive_a(st, lv, ar, pz, ab);
      step();
      m_exp = 0;
      if (ab) begin
        m_run = 0; m_done = 0; m_count = 0;
      end else if (!m_run && st) begin
        if (lv != 0) begin
          m_count = lv; m_rv = lv; m_mode = ar; m_left = P; m_run = 1; m_done = 0;
        end else begin
          m_count = 0; m_done = 1; m_exp = 1;
        end
      end else if (m_run && !pz) begin
        m_left--;
        if (m_left == 0) begin
          m_left = P;
          if (m_count > 1) m_count--;
          else begin
            m_exp = 1;
            if (m_mode) m_count = m_rv;
            else begin m_count = 0; m_run = 0; m_done = 1; end
          end
        end
      end
      checks++;
      if (ia.count !== 8'(m_count) || ia.busy !== m_run || ia.done !== m_done || ia.expired !== m_exp) begin
        errors++;
        $display("FAIL random c=%0d got c=%0d b=%b d=%b x=%b want c=%0d b=%b d=%b x=%b",
                 c, ia.count, ia.busy, ia.done, ia.expired, m_count, m_run, m_done, m_exp);
      end
    end
    drive_a(0, 0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pause();
    test_reload();
    test_zero_load();
    test_start_ignored();
    test_abort_start_done();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
